qpsk_symbol_mapper: RTL and testbench

Downstream consumer of the serial pseudo-random bit generator in the QPSK modulator chain. Collects the incoming bit stream into dibits and maps each dibit to a signed I/Q amplitude pair with per-axis Gray coding. Presents symbols on a ready/valid interface to the pulse-shaping/DAC stage. Backpressures the bit source when its one-symbol output register is full.

---
 rtl/qpsk_pkg.sv | 20 ++
 rtl/qpsk_symbol_mapper.sv | 88 ++++++++
 tb/tb_qpsk_symbol_mapper.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_pkg.sv
// Shared QPSK definitions: pairing states, default constellation constants, bit-to-amplitude map.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package qpsk_pkg;

    // Pairing state: no stored bit, or first bit of a dibit held
    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pair_state_t;

    localparam int DEFAULT_AMP_W = 8;
    localparam int DEFAULT_AMP   = 90;

    // Gray-coded per-axis map: bit 0 -> +amp, bit 1 -> -amp
    function automatic int amp_of_bit(input logic b, input int amp);
        return b ? -amp : amp;
    endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Pairs serial bits into dibits and maps each to a signed Gray-coded I/Q symbol.
// Latency: symbol valid the cycle after the second bit of a dibit is accepted.
// Backpressure: bit_ready drops in HALF while the output register holds an untaken symbol.
module qpsk_symbol_mapper
    import qpsk_pkg::*;
#(
    parameter int AMP_W = DEFAULT_AMP_W,
    parameter int AMP   = DEFAULT_AMP,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic                    bit_ready,
    input  logic                    pair_clr,
    output logic signed [AMP_W-1:0] i_out,
    output logic signed [AMP_W-1:0] q_out,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic [CNT_W-1:0]        sym_count
);

    pair_state_t state_q, state_d;
    logic        b0_q, b0_d;
    logic        load;
    logic        accept;
    logic        handoff;

    // In HALF the next accepted bit completes a symbol, so it needs room in
    // the output register (either empty or draining this very cycle).
    assign bit_ready = (state_q == EMPTY) || !sym_valid || sym_ready;
    assign accept    = bit_valid && bit_ready;
    assign handoff   = sym_valid && sym_ready;

    // Next pairing state; pair_clr realigns so an accepted bit becomes a fresh b0
    always_comb begin
        state_d = state_q;
        b0_d    = b0_q;
        load    = 1'b0;
        if (pair_clr) begin
            state_d = EMPTY;
            if (accept) begin
                state_d = HALF;
                b0_d    = bit_in;
            end
        end else if (accept) begin
            unique case (state_q)
                EMPTY: begin
                    state_d = HALF;
                    b0_d    = bit_in;
                end
                HALF: begin
                    state_d = EMPTY;
                    load    = 1'b1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Pairing state, output symbol register and handoff counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            b0_q      <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
            sym_valid <= 1'b0;
            sym_count <= '0;
        end else begin
            state_q <= state_d;
            b0_q    <= b0_d;
            // A load in the same cycle as a handoff replaces the taken symbol
            if (load) begin
                i_out     <= AMP_W'(amp_of_bit(b0_q, AMP));
                q_out     <= AMP_W'(amp_of_bit(bit_in, AMP));
                sym_valid <= 1'b1;
            end else if (handoff) begin
                sym_valid <= 1'b0;
            end
            if (handoff) begin
                sym_count <= sym_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_qpsk_symbol_mapper.sv
// Bench for qpsk_symbol_mapper: two instances (8-bit/90/16-bit count, 4-bit/7/4-bit count) share stimulus.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: stimulus holds a refused bit until it is accepted.
module tb_qpsk_symbol_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, bit_in, bit_valid, pair_clr, sym_ready;
    logic rdy_a, rdy_b, sv_a, sv_b;
    logic signed [7:0] i_a, q_a;
    logic signed [3:0] i_b, q_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    qpsk_symbol_mapper #(.AMP_W(8), .AMP(90), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy_a),
        .pair_clr(pair_clr), .i_out(i_a), .q_out(q_a), .sym_valid(sv_a),
        .sym_ready(sym_ready), .sym_count(cnt_a)
    );

    qpsk_symbol_mapper #(.AMP_W(4), .AMP(7), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(rdy_b),
        .pair_clr(pair_clr), .i_out(i_b), .q_out(q_b), .sym_valid(sv_b),
        .sym_ready(sym_ready), .sym_count(cnt_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending bit queue, last symbol amplitudes, handoff count
    bit pend[$];
    bit m_valid = 0;
    bit m_rdy   = 1;
    int m_ia = 0, m_qa = 0, m_ib = 0, m_qb = 0, m_cnt = 0;
    bit obs_rdy_a, obs_rdy_b;

    function automatic logic [32:0] exp_a();
        return {m_valid, 8'(m_ia), 8'(m_qa), 16'(m_cnt)};
    endfunction

    function automatic logic [12:0] exp_b();
        return {m_valid, 4'(m_ib), 4'(m_qb), 4'(m_cnt)};
    endfunction

    // One clock of stimulus; advances the model with what the edge should do
    task automatic tick(input bit r, input bit bv, input bit b, input bit sr, input bit pc,
                        output bit acc_o);
        bit acc, ho, b0;
        rst = r; bit_valid = bv; bit_in = b; sym_ready = sr; pair_clr = pc;
        #1;
        m_rdy     = (pend.size() == 0) || !m_valid || sr;
        obs_rdy_a = rdy_a;
        obs_rdy_b = rdy_b;
        acc = bv && m_rdy && !r;
        ho  = m_valid && sr;
        if (r) begin
            pend.delete();
            m_valid = 0;
            m_ia = 0; m_qa = 0; m_ib = 0; m_qb = 0; m_cnt = 0;
        end else begin
            if (ho) begin
                m_cnt++;
                m_valid = 0;
            end
            if (pc) pend.delete();
            if (acc) begin
                if (pc || pend.size() == 0) begin
                    pend.push_back(b);
                end else begin
                    b0 = pend.pop_front();
                    m_ia = b0 ? -90 : 90;
                    m_qa = b  ? -90 : 90;
                    m_ib = b0 ? -7 : 7;
                    m_qb = b  ? -7 : 7;
                    m_valid = 1;
                end
            end
        end
        acc_o = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        tick(1, 0, 0, 0, 0, acc);
        tick(1, 1, 1, 1, 1, acc);
        tick(0, 0, 0, 0, 0, acc);
        total++;
        if ({sv_a, i_a, q_a, cnt_a} !== 33'd0)
            begin bad++; $display("FAIL reset_a got=%h want=0", {sv_a, i_a, q_a, cnt_a}); end
        total++;
        if ({sv_b, i_b, q_b, cnt_b} !== 13'd0)
            begin bad++; $display("FAIL reset_b got=%h want=0", {sv_b, i_b, q_b, cnt_b}); end
        total++;
        if (obs_rdy_a !== 1'b1 || obs_rdy_b !== 1'b1)
            begin bad++; $display("FAIL reset_ready got=%b%b want=11", obs_rdy_a, obs_rdy_b); end
    endtask

    task automatic test_stream();
        bit s[6] = '{1, 0, 0, 1, 0, 1};
        bit acc;
        for (int k = 0; k < 7; k++) begin
            tick(0, k < 6, (k < 6) ? s[k] : 1'b0, 1, 0, acc);
            total++;
            if ({sv_a, i_a, q_a, cnt_a} !== exp_a())
                begin bad++; $display("FAIL stream_a k=%0d got=%h want=%h", k, {sv_a, i_a, q_a, cnt_a}, exp_a()); end
            total++;
            if (obs_rdy_a !== m_rdy)
                begin bad++; $display("FAIL stream_ready k=%0d got=%b want=%b", k, obs_rdy_a, m_rdy); end
            if (k == 1) begin
                total++;
                if (i_a !== -90 || q_a !== 90)
                    begin bad++; $display("FAIL stream_sym1 got=%0d,%0d want=-90,90", i_a, q_a); end
            end
        end
        total++;
        if (cnt_a !== 16'd3)
            begin bad++; $display("FAIL stream_count got=%0d want=3", cnt_a); end
    endtask

    task automatic test_backpressure();
        bit bv = 0, b = 0, acc, saw_block = 0;
        tick(1, 0, 0, 0, 0, acc);
        for (int k = 0; k < 20; k++) begin
            if (!bv) begin bv = 1; b = 1'($urandom_range(1)); end
            tick(0, bv, b, k >= 10, 0, acc);
            if (acc) bv = 0;
            if (k < 10 && !obs_rdy_a) saw_block = 1;
            total++;
            if ({sv_a, i_a, q_a, cnt_a} !== exp_a())
                begin bad++; $display("FAIL bp_a k=%0d got=%h want=%h", k, {sv_a, i_a, q_a, cnt_a}, exp_a()); end
            total++;
            if ({sv_b, i_b, q_b, cnt_b} !== exp_b())
                begin bad++; $display("FAIL bp_b k=%0d got=%h want=%h", k, {sv_b, i_b, q_b, cnt_b}, exp_b()); end
            total++;
            if (obs_rdy_a !== m_rdy || obs_rdy_b !== m_rdy)
                begin bad++; $display("FAIL bp_ready k=%0d got=%b%b want=%b", k, obs_rdy_a, obs_rdy_b, m_rdy); end
        end
        total++;
        if (saw_block !== 1'b1)
            begin bad++; $display("FAIL bp_block got=%b want=1", saw_block); end
    endtask

    task automatic test_pair_clr();
        bit acc;
        tick(1, 0, 0, 0, 0, acc);
        tick(0, 1, 1, 0, 0, acc);
        tick(0, 1, 0, 0, 1, acc);
        tick(0, 1, 0, 0, 0, acc);
        tick(0, 0, 0, 0, 0, acc);
        total++;
        if (sv_a !== 1'b1 || i_a !== 90 || q_a !== 90 || cnt_a !== 16'd0)
            begin bad++; $display("FAIL pair_clr got=%b,%0d,%0d,%0d want=1,90,90,0", sv_a, i_a, q_a, cnt_a); end
        total++;
        if ({sv_a, i_a, q_a, cnt_a} !== exp_a())
            begin bad++; $display("FAIL pair_clr_model got=%h want=%h", {sv_a, i_a, q_a, cnt_a}, exp_a()); end
    endtask

    task automatic test_reset_mid();
        bit acc;
        tick(1, 0, 0, 0, 0, acc);
        tick(0, 1, 1, 1, 0, acc);
        tick(0, 1, 1, 1, 0, acc);
        tick(0, 1, 0, 1, 0, acc);
        tick(0, 1, 0, 0, 0, acc);
        tick(0, 1, 1, 0, 0, acc);
        tick(1, 1, 0, 1, 0, acc);
        total++;
        if ({sv_a, i_a, q_a, cnt_a} !== 33'd0)
            begin bad++; $display("FAIL rst_mid got=%h want=0", {sv_a, i_a, q_a, cnt_a}); end
        tick(0, 1, 1, 0, 0, acc);
        tick(0, 1, 0, 0, 0, acc);
        total++;
        if (sv_a !== 1'b1 || i_a !== -90 || q_a !== 90)
            begin bad++; $display("FAIL rst_mid_fresh got=%b,%0d,%0d want=1,-90,90", sv_a, i_a, q_a); end
    endtask

    task automatic test_wrap();
        bit acc;
        tick(1, 0, 0, 0, 0, acc);
        for (int k = 0; k < 37; k++) tick(0, k < 36, 1'($urandom_range(1)), 1, 0, acc);
        total++;
        if (cnt_b !== 4'd2)
            begin bad++; $display("FAIL wrap_b got=%0d want=2", cnt_b); end
        total++;
        if (cnt_a !== 16'd18)
            begin bad++; $display("FAIL wrap_a got=%0d want=18", cnt_a); end
    endtask

    task automatic test_small_amp();
        bit d0[4] = '{0, 1, 1, 0};
        bit d1[4] = '{0, 0, 1, 1};
        int ei[4] = '{7, -7, -7, 7};
        int eq[4] = '{7, 7, -7, -7};
        bit acc;
        tick(1, 0, 0, 0, 0, acc);
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, d0[k], 1, 0, acc);
            tick(0, 1, d1[k], 1, 0, acc);
            total++;
            if (sv_b !== 1'b1 || int'(i_b) != ei[k] || int'(q_b) != eq[k])
                begin bad++; $display("FAIL small_amp k=%0d got=%b,%0d,%0d want=1,%0d,%0d", k, sv_b, i_b, q_b, ei[k], eq[k]); end
        end
    endtask

    task automatic test_random();
        bit bv = 0, b = 0, acc, r, sr, pc;
        tick(1, 0, 0, 0, 0, acc);
        for (int k = 0; k < 400; k++) begin
            r  = ($urandom_range(99) == 0);
            sr = 1'($urandom_range(1));
            pc = ($urandom_range(15) == 0);
            if (!bv) begin bv = ($urandom_range(3) != 0); b = 1'($urandom_range(1)); end
            tick(r, bv, b, sr, pc, acc);
            if (acc || r) bv = 0;
            total++;
            if ({sv_a, i_a, q_a, cnt_a} !== exp_a())
                begin bad++; $display("FAIL rand_a k=%0d got=%h want=%h", k, {sv_a, i_a, q_a, cnt_a}, exp_a()); end
            total++;
            if ({sv_b, i_b, q_b, cnt_b} !== exp_b())
                begin bad++; $display("FAIL rand_b k=%0d got=%h want=%h", k, {sv_b, i_b, q_b, cnt_b}, exp_b()); end
            total++;
            if (obs_rdy_a !== m_rdy || obs_rdy_b !== m_rdy)
                begin bad++; $display("FAIL rand_ready k=%0d got=%b%b want=%b", k, obs_rdy_a, obs_rdy_b, m_rdy); end
        end
    endtask

    initial begin
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; pair_clr = 1'b0; sym_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_pair_clr();
        test_reset_mid();
        test_wrap();
        test_small_amp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
